// File: rtl/move_replay_source_if.sv
// rtl/move_replay_source_if.sv - history RAM read port and key handshake bundle for the replay source
interface move_replay_source_if;
  logic [5:0] hist_rd_addr;
  logic [5:0] hist_rd_data;
  logic [3:0] pressed_index;
  logic       key_valid;
  logic       key_ready;
  logic       ok_pulse;
  logic       move_accepted;

  modport master (
    output hist_rd_addr, pressed_index, key_valid, ok_pulse,
    input  hist_rd_data, key_ready, move_accepted
  );

  modport slave (
    input  hist_rd_addr, pressed_index, key_valid, ok_pulse,
    output hist_rd_data, key_ready, move_accepted
  );
endinterface

// File: rtl/move_replay_source.sv
// rtl/move_replay_source.sv - replays stored gomoku moves as keyboard key presses
module move_replay_source #(
  parameter int MAX_MOVES   = 64,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 start,
  input  logic [6:0]           move_count,
  move_replay_source_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [6:0]           moves_sent
);
  localparam int CMAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_LATCH    = 4'd2;
  localparam logic [3:0] S_SEND_X   = 4'd3;
  localparam logic [3:0] S_GAP_X    = 4'd4;
  localparam logic [3:0] S_SEND_Y   = 4'd5;
  localparam logic [3:0] S_GAP_Y    = 4'd6;
  localparam logic [3:0] S_OK       = 4'd7;
  localparam logic [3:0] S_WAIT_ACK = 4'd8;
  localparam logic [3:0] S_GAP      = 4'd9;
  localparam logic [3:0] S_FINISH   = 4'd10;

  logic [3:0]    state;
  logic [6:0]    count;
  logic [2:0]    y_reg;
  logic [CW-1:0] cnt;
  logic [6:0]    clamped;

  // Requests longer than the history RAM are cut to its depth
  assign clamped = (move_count > 7'(MAX_MOVES)) ? 7'(MAX_MOVES) : move_count;

  // Replay sequencer: fetch a move, emit x-key, y-key, confirm, then wait for the game's ack.
  // The RAM address is updated on the transition into FETCH so the word is readable in LATCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      count             <= '0;
      y_reg             <= '0;
      cnt               <= '0;
      bus.hist_rd_addr  <= '0;
      bus.pressed_index <= '0;
      bus.key_valid     <= 1'b0;
      bus.ok_pulse      <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      moves_sent        <= '0;
    end else begin
      done         <= 1'b0;
      bus.ok_pulse <= 1'b0;
      if (!en) begin
        state         <= S_IDLE;
        bus.key_valid <= 1'b0;
        busy          <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              count            <= clamped;
              moves_sent       <= '0;
              error            <= 1'b0;
              busy             <= 1'b1;
              bus.hist_rd_addr <= '0;
              state            <= (clamped == 7'd0) ? S_FINISH : S_FETCH;
            end
          end
          S_FETCH: state <= S_LATCH;
          S_LATCH: begin
            y_reg             <= bus.hist_rd_data[5:3];
            bus.pressed_index <= {1'b0, bus.hist_rd_data[2:0]};
            bus.key_valid     <= 1'b1;
            state             <= S_SEND_X;
          end
          S_SEND_X: begin
            if (bus.key_valid && bus.key_ready) begin
              bus.key_valid <= 1'b0;
              cnt           <= '0;
              state         <= S_GAP_X;
            end
          end
          S_GAP_X: begin
            if (cnt == '0) begin
              cnt <= CW'(1);
            end else begin
              bus.pressed_index <= {1'b1, y_reg};
              bus.key_valid     <= 1'b1;
              state             <= S_SEND_Y;
            end
          end
          S_SEND_Y: begin
            if (bus.key_valid && bus.key_ready) begin
              bus.key_valid <= 1'b0;
              cnt           <= '0;
              state         <= S_GAP_Y;
            end
          end
          S_GAP_Y: begin
            if (cnt == '0) begin
              cnt <= CW'(1);
            end else begin
              bus.ok_pulse <= 1'b1;
              state        <= S_OK;
            end
          end
          S_OK: begin
            cnt   <= '0;
            state <= S_WAIT_ACK;
          end
          S_WAIT_ACK: begin
            if (bus.move_accepted) begin
              moves_sent <= moves_sent + 7'd1;
              cnt        <= CW'(GAP_CYCLES - 1);
              state      <= S_GAP;
            end else if (cnt == CW'(ACK_TIMEOUT - 2)) begin
              error <= 1'b1;
              state <= S_FINISH;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_GAP: begin
            if (cnt == '0) begin
              if (moves_sent == count) begin
                state <= S_FINISH;
              end else begin
                bus.hist_rd_addr <= moves_sent[5:0];
                state            <= S_FETCH;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          S_FINISH: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_move_replay_source.sv
// tb/tb_move_replay_source.sv - table-driven and randomized bench for move_replay_source
module tb_move_replay_source;
  localparam int MAX_MOVES   = 64;
  localparam int GAP_CYCLES  = 16;
  localparam int ACK_TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic [6:0] move_count = '0;
  logic       busy, done, error;
  logic [6:0] moves_sent;

  move_replay_source_if bus ();

  move_replay_source #(
    .MAX_MOVES(MAX_MOVES), .GAP_CYCLES(GAP_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .move_count(move_count),
    .bus(bus), .busy(busy), .done(done), .error(error), .moves_sent(moves_sent)
  );

  always #5 clk = ~clk;

  // history RAM, one cycle read latency
  logic [5:0] mem [64];
  always @(posedge clk) bus.hist_rd_data <= mem[bus.hist_rd_addr];

  // consumer: ready follows valid one cycle later, optionally stalled on one chosen word
  int stall_word = -1;
  int stall_len = 0;
  int xfer_count = 0;
  int wait_ctr = 0;
  always @(posedge clk) begin
    if (!rst_n || !bus.key_valid) begin
      bus.key_ready <= 1'b0;
      wait_ctr      <= 0;
    end else begin
      wait_ctr      <= wait_ctr + 1;
      bus.key_ready <= (xfer_count != stall_word) || (wait_ctr >= stall_len);
    end
    if (rst_n && bus.key_valid && bus.key_ready) xfer_count <= xfer_count + 1;
  end

  // game: acknowledges a move ack_delay cycles after the confirm; 0 means never
  int ack_delay = 0;
  int ack_ctr = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      ack_ctr           <= 0;
      bus.move_accepted <= 1'b0;
    end else begin
      bus.move_accepted <= (ack_ctr == 1);
      if (bus.ok_pulse) ack_ctr <= ack_delay;
      else if (ack_ctr > 0) ack_ctr <= ack_ctr - 1;
    end
  end

  // observer: logs transfers and pulses with their cycle numbers
  int cyc = 0, key_n = 0, ok_n = 0, done_n = 0, hold_err = 0, max_addr = 0;
  int ok_cyc = 0, done_cyc = 0, acc_cyc = 0, start_cyc = 0;
  logic [3:0] key_log [4096];
  int         key_cyc [4096];
  logic       pend = 1'b0;
  logic [3:0] pend_idx = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      cyc <= cyc + 1;
      if (pend && (!bus.key_valid || bus.pressed_index != pend_idx)) hold_err <= hold_err + 1;
      pend     <= bus.key_valid && !bus.key_ready && en;
      pend_idx <= bus.pressed_index;
      if (bus.key_valid && bus.key_ready) begin
        key_log[key_n] <= bus.pressed_index;
        key_cyc[key_n] <= cyc;
        key_n          <= key_n + 1;
      end
      if (bus.ok_pulse) begin
        ok_n   <= ok_n + 1;
        ok_cyc <= cyc;
      end
      if (done) begin
        done_n   <= done_n + 1;
        done_cyc <= cyc;
      end
      if (bus.move_accepted) acc_cyc <= cyc;
      if (start && en) start_cyc <= cyc;
      if (int'(bus.hist_rd_addr) > max_addr) max_addr <= int'(bus.hist_rd_addr);
    end
  end

  typedef struct {
    int cnt; int ack; int stall; int stall_at; int restart;
    int exp_moves; int exp_err; int exp_keys; int exp_oks;
  } case_t;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // key i of a replay: even = x-key of move i/2, odd = y-key
  function automatic int exp_key(input int i);
    logic [5:0] m;
    m = mem[i / 2];
    return (i % 2 == 0) ? int'({1'b0, m[2:0]}) : int'({1'b1, m[5:3]});
  endfunction

  task automatic run_case(input case_t c, input string tag);
    int bk, bo, bd, k;
    bk = key_n;
    bo = ok_n;
    bd = done_n;
    ack_delay  = c.ack;
    stall_word = (c.stall > 0) ? xfer_count + c.stall_at : -1;
    stall_len  = c.stall;
    move_count = 7'(c.cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (done_n == bd && k < 20000) begin
      tick();
      k++;
      start = (c.restart != 0 && k == c.restart);
    end
    start = 1'b0;
    check({tag, " done_seen"}, int'(done_n != bd), 1);
    tick();
    tick();
    check({tag, " done_count"}, done_n - bd, 1);
    check({tag, " moves_sent"}, int'(moves_sent), c.exp_moves);
    check({tag, " error"}, int'(error), c.exp_err);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " keys"}, key_n - bk, c.exp_keys);
    check({tag, " oks"}, ok_n - bo, c.exp_oks);
    if (key_n - bk == c.exp_keys)
      for (int i = 0; i < c.exp_keys; i++) check({tag, " key"}, int'(key_log[bk + i]), exp_key(i));
  endtask

  initial begin
    case_t tbl [5];
    case_t c;
    int bk, bd, k, n;

    for (int i = 0; i < 64; i++) mem[i] = 6'($urandom);
    mem[0] = 6'o35;
    mem[1] = 6'o12;
    mem[2] = 6'o64;

    //          cnt ack stall at restart moves err keys oks
    tbl[0] = '{  1,  3,  0,   0,  0,      1,   0,   2,   1};
    tbl[1] = '{  3,  2,  5,   1, 10,      3,   0,   6,   3};
    tbl[2] = '{  1,  0,  0,   0,  0,      0,   1,   2,   1};
    tbl[3] = '{  0,  3,  0,   0,  0,      0,   0,   0,   0};
    tbl[4] = '{100,  1,  0,   0,  0,     64,   0, 128,  64};

    // reset held with start asserted
    rst_n = 1'b0; en = 1'b1; start = 1'b1; move_count = 7'd5;
    repeat (3) tick();
    check("reset_outputs", int'({busy, done, error, moves_sent, bus.key_valid, bus.ok_pulse,
                                 bus.pressed_index, bus.hist_rd_addr}), 0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check("post_reset_busy", int'(busy), 0);
    check("post_reset_keys", key_n, 0);

    for (int i = 0; i < 5; i++) begin
      bk = key_n;
      run_case(tbl[i], $sformatf("tbl%0d", i));
      case (i)
        0: begin
          check("word_spacing", key_cyc[bk + 1] - key_cyc[bk], 4);
          check("ok_after_y", ok_cyc - key_cyc[bk + 1], 3);
          check("done_after_ack", done_cyc - acc_cyc, GAP_CYCLES + 2);
        end
        1: begin
          check("stalled_spacing", key_cyc[bk + 1] - key_cyc[bk], 9);
          check("word_held", hold_err, 0);
        end
        2: check("timeout_latency", done_cyc - ok_cyc, ACK_TIMEOUT + 1);
        3: check("empty_latency", done_cyc - start_cyc, 2);
        4: begin
          check("peak_addr", max_addr, 63);
          check("last_addr", int'(bus.hist_rd_addr), 63);
        end
        default: ;
      endcase
    end

    // en dropped (with a simultaneous start) while the second move's y-key is stalled
    bk = key_n;
    ack_delay = 2;
    stall_word = xfer_count + 3;
    stall_len = 50;
    move_count = 7'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(bus.key_valid && bus.pressed_index[3] && key_n - bk == 3) && k < 2000) begin
      tick();
      k++;
    end
    check("reach_send_y", int'(k < 2000), 1);
    bd = done_n;
    en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_valid", int'(bus.key_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_moves_kept", int'(moves_sent), 1);
    repeat (5) tick();
    check("abort_no_done", done_n - bd, 0);
    check("abort_stays_idle", int'(busy), 0);
    en = 1'b1;
    stall_word = -1;
    tick();
    run_case('{1, 3, 0, 0, 0, 1, 0, 2, 1}, "rerun");

    // randomized replays against the move-list model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) mem[i] = 6'($urandom);
      c.cnt = $urandom_range(1, 5);
      n = (c.cnt < MAX_MOVES) ? c.cnt : MAX_MOVES;
      c.ack = $urandom_range(1, 12);
      c.stall = $urandom_range(0, 6);
      c.stall_at = $urandom_range(0, 2 * n - 1);
      c.restart = ($urandom_range(0, 1) == 1) ? $urandom_range(3, 20) : 0;
      c.exp_moves = n;
      c.exp_err = 0;
      c.exp_keys = 2 * n;
      c.exp_oks = n;
      run_case(c, $sformatf("rand%0d", r));
    end
    check("hold_total", hold_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/move_replay_source.md
Name: move_replay_source

Overview:
Demo/replay source for the gomoku board. It reads a stored move list (6-bit {y,x} entries) from a synchronous history RAM and drives the same key_valid/key_ready handshake as the keyboard, so the game FSM sees ordinary key presses. For each move it emits an x-key, then a y-key, then a one-cycle OK pulse, and waits for the game's move-accepted acknowledge before sending the next move. It is muxed in front of the keyboard interface when demo mode is selected.

Parameters:
MAX_MOVES, 64, maximum replayable moves; move_count is clamped to this value
GAP_CYCLES, 16, idle cycles after each accepted move before fetching the next
ACK_TIMEOUT, 1024, cycles to wait for move_accepted before aborting with error

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
en  in  1  block enable; low aborts any replay
start  in  1  one-cycle pulse that begins a replay from entry 0
move_count  in  7  number of moves to replay; sampled on start
hist_rd_addr  out  6  history RAM read address
hist_rd_data  in  6  history RAM data {y[2:0],x[2:0]}, valid 1 cycle after address
pressed_index  out  4  key code: {1'b0,x} for an x-key, {1'b1,y} for a y-key
key_valid  out  1  key word valid
key_ready  in  1  consumer ready; a transfer occurs on a cycle with key_valid && key_ready
ok_pulse  out  1  one-cycle confirm, equivalent to a btn_ok key-down
move_accepted  in  1  one-cycle pulse from the game when a move was judged valid
busy  out  1  replay in progress
done  out  1  one-cycle pulse when replay ends (normal or error)
error  out  1  sticky; set on ack timeout, cleared on start
moves_sent  out  7  number of moves acknowledged in the current replay

Behaviour:
- All outputs are registered. Reset value is 0 for every output. The FSM resets to IDLE.
- States: IDLE, FETCH, LATCH, SEND_X, GAP_X, SEND_Y, GAP_Y, OK, WAIT_ACK, GAP, FINISH.
- IDLE: on start && en, latch count = min(move_count, MAX_MOVES), clear moves_sent and error, set busy=1.
  - If count == 0, go to FINISH; otherwise go to FETCH.
  - start while busy is ignored.
- FETCH: drive hist_rd_addr = moves_sent[5:0], go to LATCH.
- LATCH: capture hist_rd_data into an internal register, go to SEND_X.
- SEND_X: key_valid=1, pressed_index={0,x}, held stable until the transfer cycle.
  - key_valid drops the cycle after the transfer.
  - Go to GAP_X.
- GAP_X / GAP_Y: key_valid is held low for exactly 2 cycles. The consumer's ready is registered from valid and must fall before the next word.
- SEND_Y: same rules as SEND_X with pressed_index={1,y}. Go to GAP_Y, then OK.
- OK: ok_pulse=1 for exactly one cycle, then WAIT_ACK with the timeout counter cleared.
- WAIT_ACK:
  - On move_accepted: moves_sent += 1, then go to GAP with a counter of GAP_CYCLES.
  - If the counter reaches ACK_TIMEOUT-1 without move_accepted: set error=1 and go to FINISH. This covers an occupied cell or invalid move, where the game returns to waiting for input without acking.
  - move_accepted outside WAIT_ACK is ignored.
- GAP: after GAP_CYCLES cycles, go to FINISH if moves_sent == count, else to FETCH.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. moves_sent and error hold until the next start.
- en low in any state: the next cycle is IDLE, with key_valid, ok_pulse and busy at 0. done is not pulsed; moves_sent is retained.
- rst_n mid-replay: immediate return to reset values. No partial word is left asserted.
- Simultaneous start and en falling: en wins, so the block stays IDLE.
- Widths: moves_sent and count are 7 bits, so 64 is representable. hist_rd_addr uses the low 6 bits and never wraps within a replay.

Test Plan:
- Reset with start held high: all outputs 0, no key_valid, busy 0 until rst_n releases and a new start pulse arrives.
- RAM[0]=6'o35 (y=3, x=5), move_count=1, consumer ready registered from valid, ack 3 cycles after ok_pulse:
  - pressed_index 4'h5 then 4'hB, each held until ready, with 2 low-valid cycles between words.
  - One ok_pulse, moves_sent=1, then done after GAP_CYCLES with error=0.
- move_count=3, RAM entries 0..2 distinct, consumer ready stalled 5 cycles on the second word:
  - Word held stable while stalled, no duplicated transfer.
  - 6 transfers and 3 ok_pulses in total, moves_sent=3.
- No move_accepted after the first ok_pulse: error=1 and done pulses exactly ACK_TIMEOUT cycles after WAIT_ACK entry, moves_sent=0.
- en dropped while in SEND_Y: key_valid=0 the next cycle, busy=0, no done pulse. A later start replays from entry 0.
- move_count=0, then move_count=100 with MAX_MOVES=64:
  - move_count=0 gives done one cycle after FINISH entry with no key traffic.
  - move_count=100 stops after 64 acks with moves_sent=64 and hist_rd_addr peaking at 63.
